// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key-expansion sequencer: loads a 256-bit key and streams RK0..RK14 over
// a valid/ready port, borrowing an external SubWord S-box and the shared rcon block.
module aes256_key_sched_ctrl #(
    parameter int NUM_RK    = 15,
    parameter int LAST_RCON = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         done,
    output logic [3:0]   rcon_index,
    input  logic [31:0]  rcon_in,
    output logic [31:0]  sub_word_in,
    input  logic [31:0]  sub_word_out
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_OUT  | round key rk_index presented, waiting for handshake
    // S_CALC | one-cycle derivation of the next four words
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OUT  = 2'd1,
        S_CALC = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(NUM_RK - 1);
    localparam logic [3:0] MAX_RCON = 4'(LAST_RCON);

    state_t         r_state, w_state_nxt;
    logic [255:0]   r_window, w_window_nxt;
    logic [3:0]     r_cnt, w_cnt_nxt;
    logic           r_valid, w_valid_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_done, w_done_nxt;

    logic [31:0]    w_last;
    logic [31:0]    w_temp;
    logic [31:0]    w_sub_in;
    logic [3:0]     w_rcon_idx;
    logic [3:0]     w_rcon_raw;
    logic [31:0]    w_n0, w_n1, w_n2, w_n3;
    logic           w_hs;
    logic           w_unused;

    assign w_last     = r_window[31:0];
    assign w_hs       = r_valid & rk_ready;
    assign w_rcon_raw = (r_cnt - 4'd1) >> 1;
    assign w_unused   = ^rcon_in[23:0];

    assign w_n0 = r_window[255:224] ^ w_temp;
    assign w_n1 = r_window[223:192] ^ w_n0;
    assign w_n2 = r_window[191:160] ^ w_n1;
    assign w_n3 = r_window[159:128] ^ w_n2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_window <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_window <= w_window_nxt;
            r_cnt    <= w_cnt_nxt;
            r_valid  <= w_valid_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_window_nxt = r_window;
        w_cnt_nxt    = r_cnt;
        w_valid_nxt  = r_valid;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_sub_in     = '0;
        w_rcon_idx   = '0;
        w_temp       = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_window_nxt = key;
                    w_cnt_nxt    = '0;
                    w_valid_nxt  = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = S_OUT;
                end
            end
            S_OUT: begin
                if (w_hs) begin
                    if (r_cnt == LAST_CNT) begin
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        // RK1 is already in the window, so no CALC cycle is needed
                        w_cnt_nxt = 4'd1;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                // odd cnt means the next key number is even: RotWord + rcon path
                if (r_cnt[0]) begin
                    w_sub_in   = {w_last[23:0], w_last[31:24]};
                    w_rcon_idx = (w_rcon_raw > MAX_RCON) ? MAX_RCON : w_rcon_raw;
                    w_temp     = sub_word_out ^ {rcon_in[31:24], 24'h0};
                end else begin
                    w_sub_in   = w_last;
                    w_temp     = sub_word_out;
                end
                w_window_nxt = {r_window[127:0], w_n0, w_n1, w_n2, w_n3};
                w_cnt_nxt    = r_cnt + 4'd1;
                w_valid_nxt  = 1'b1;
                w_state_nxt  = S_OUT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rk_data     = (r_cnt == 4'd0) ? r_window[255:128] : r_window[127:0];
    assign rk_index    = r_cnt;
    assign rk_valid    = r_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign rcon_index  = w_rcon_idx;
    assign sub_word_in = w_sub_in;

endmodule
